// File: rtl/pifo_drain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pifo_drain_ctrl_pkg
//   Shared definitions for the PIFO drain controller: FSM state encodings and
//   small sizing helpers used by the top module and the drop FIFO.
//   No ports (package).
// -----------------------------------------------------------------------------
package pifo_drain_ctrl_pkg;

  // Drain FSM states. Encodings are fixed so that debug taps and any software
  // reading a state mirror see stable values.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_CONGEST = 2'd2
  } drain_state_e;

  // Width needed to hold the values 0..max_val inclusive.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pifo_drain_ctrl_drop_fifo.sv
// -----------------------------------------------------------------------------
// drain_drop_fifo
//   Small synchronous FIFO for the PIFO drop stream. The writer has no
//   backpressure: a write into a full FIFO is discarded and reported on 'lost'
//   unless a read happens in the same cycle, in which case the write is kept.
//   The head entry is presented directly on rd_data (first-word fall-through).
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_valid, wr_data   write strobe and payload (no ready)
//   rd_valid, rd_ready  read handshake; rd_data is the current head
//   full                FIFO holds DEPTH entries
//   lost                one-cycle strobe: the current write is discarded
// Parameters
//   DW     payload width
//   DEPTH  entries, power of 2, >= 2
// -----------------------------------------------------------------------------
module drain_drop_fifo #(
  parameter int DW    = 48,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          lost
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [DW-1:0] mem_reg [DEPTH];

  logic empty;
  logic rd_en;
  logic wr_en;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                    (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign rd_valid = !empty;
  assign rd_en    = rd_valid && rd_ready;
  // A simultaneous read frees the slot the write is about to take.
  assign wr_en    = wr_valid && (!full || rd_en);
  assign lost     = wr_valid && full && !rd_en;
  assign rd_data  = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage is cleared on reset so the head outputs read 0 while empty.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// pifo_drain_ctrl
//   Consumer for the PIFO output side. Pops scheduled descriptors while
//   downstream credits are available and forwards them through a registered
//   output stage. Buffers the (unthrottled) PIFO drop stream in a small FIFO
//   for the drop/free path and drives the pifo_in_drop congestion hint.
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   pifo_out_ready/valid/prio/data   pop interface from the PIFO head
//   pifo_out_drop_valid/prio/data    dropped-entry strobe (no ready)
//   m_desc_valid/ready/prio/data     forwarded descriptor stream
//   credit_return                    one-cycle pulse, returns one credit
//   m_drop_valid/ready/prio/data     drop release stream (FIFO head)
//   pifo_in_drop                     registered congestion hint
//   stat_drop_cnt, stat_lost_cnt     drop statistics (see macro below)
//   credit_err                       sticky: credit returned while at CREDIT_MAX
// Configuration
//   PIFO_DRAIN_STATS_EN  when defined, stat_drop_cnt/stat_lost_cnt count;
//                        otherwise both read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module pifo_drain_ctrl
  import pifo_drain_ctrl_pkg::*;
#(
  parameter int BITPRIO         = 16,
  parameter int BITDESC         = 32,
  parameter int CREDIT_MAX      = 8,
  parameter int DROP_FIFO_DEPTH = 4,
  parameter int STALL_THRESH    = 64
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pifo_out_ready,
  input  logic               pifo_out_valid,
  input  logic [BITPRIO-1:0] pifo_out_prio,
  input  logic [BITDESC-1:0] pifo_out_data,
  input  logic               pifo_out_drop_valid,
  input  logic [BITPRIO-1:0] pifo_out_drop_prio,
  input  logic [BITDESC-1:0] pifo_out_drop_data,
  output logic               m_desc_valid,
  input  logic               m_desc_ready,
  output logic [BITPRIO-1:0] m_desc_prio,
  output logic [BITDESC-1:0] m_desc_data,
  input  logic               credit_return,
  output logic               m_drop_valid,
  input  logic               m_drop_ready,
  output logic [BITPRIO-1:0] m_drop_prio,
  output logic [BITDESC-1:0] m_drop_data,
  output logic               pifo_in_drop,
  output logic [31:0]        stat_drop_cnt,
  output logic [15:0]        stat_lost_cnt,
  output logic               credit_err
);

  localparam int CW = count_width(CREDIT_MAX);
  localparam int SW = count_width(STALL_THRESH);
  localparam int DW = BITPRIO + BITDESC;

  // ---------------------------------------------------------------------------
  // Credits and pop handshake
  // ---------------------------------------------------------------------------
  logic [CW-1:0]      credits_reg, credits_next;
  logic               credit_err_reg, credit_err_next;
  logic               m_desc_valid_reg;
  logic [BITPRIO-1:0] m_desc_prio_reg;
  logic [BITDESC-1:0] m_desc_data_reg;
  logic               pop;

  // Pop only when a credit is held and the output register is free or being
  // emptied this cycle. Gated by rst so the PIFO never sees a pop in reset.
  assign pifo_out_ready = !rst && (credits_reg != '0) &&
                          (!m_desc_valid_reg || m_desc_ready);
  assign pop = pifo_out_ready && pifo_out_valid;

  always_comb begin
    credits_next    = credits_reg;
    credit_err_next = credit_err_reg;
    if (pop && !credit_return) begin
      credits_next = credits_reg - CW'(1);
    end else if (!pop && credit_return) begin
      // A return at full count is a downstream bug: saturate and flag it.
      if (credits_reg == CW'(CREDIT_MAX)) credit_err_next = 1'b1;
      else                                credits_next    = credits_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_reg      <= CW'(CREDIT_MAX);
      credit_err_reg   <= 1'b0;
      m_desc_valid_reg <= 1'b0;
      m_desc_prio_reg  <= '0;
      m_desc_data_reg  <= '0;
    end else begin
      credits_reg    <= credits_next;
      credit_err_reg <= credit_err_next;
      if (pop) begin
        m_desc_valid_reg <= 1'b1;
        m_desc_prio_reg  <= pifo_out_prio;
        m_desc_data_reg  <= pifo_out_data;
      end else if (m_desc_ready) begin
        m_desc_valid_reg <= 1'b0;
      end
    end
  end

  assign m_desc_valid = m_desc_valid_reg;
  assign m_desc_prio  = m_desc_prio_reg;
  assign m_desc_data  = m_desc_data_reg;
  assign credit_err   = credit_err_reg;

  // ---------------------------------------------------------------------------
  // Drop FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] drop_head;
  logic          drop_full;
  logic          drop_lost;

  drain_drop_fifo #(
    .DW    (DW),
    .DEPTH (DROP_FIFO_DEPTH)
  ) u_drop_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (pifo_out_drop_valid),
    .wr_data  ({pifo_out_drop_prio, pifo_out_drop_data}),
    .rd_valid (m_drop_valid),
    .rd_ready (m_drop_ready),
    .rd_data  (drop_head),
    .full     (drop_full),
    .lost     (drop_lost)
  );

  assign m_drop_prio = drop_head[DW-1 -: BITPRIO];
  assign m_drop_data = drop_head[BITDESC-1:0];

`ifdef PIFO_DRAIN_STATS_EN
  logic [31:0] stat_drop_cnt_reg;
  logic [15:0] stat_lost_cnt_reg;

  // Both counters wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_drop_cnt_reg <= '0;
      stat_lost_cnt_reg <= '0;
    end else begin
      if (pifo_out_drop_valid) stat_drop_cnt_reg <= stat_drop_cnt_reg + 32'd1;
      if (drop_lost)           stat_lost_cnt_reg <= stat_lost_cnt_reg + 16'd1;
    end
  end

  assign stat_drop_cnt = stat_drop_cnt_reg;
  assign stat_lost_cnt = stat_lost_cnt_reg;
`else
  logic unused_drop_lost;
  assign unused_drop_lost = drop_lost;
  assign stat_drop_cnt    = '0;
  assign stat_lost_cnt    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Congestion FSM
  // ---------------------------------------------------------------------------
  drain_state_e  state_reg, state_next;
  logic [SW-1:0] stall_cnt_reg, stall_cnt_next;
  logic          drop_full_d1_reg;
  logic          pifo_in_drop_reg, pifo_in_drop_next;
  logic          full_persist;

  // A drop FIFO stuck full for two cycles means the drop path cannot keep up.
  assign full_persist = drop_full && drop_full_d1_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_RUN;
      stall_cnt_reg    <= '0;
      drop_full_d1_reg <= 1'b0;
      pifo_in_drop_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      stall_cnt_reg    <= stall_cnt_next;
      drop_full_d1_reg <= drop_full;
      pifo_in_drop_reg <= pifo_in_drop_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    stall_cnt_next = stall_cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (credits_reg == '0) begin
          state_next     = ST_STALL;
          stall_cnt_next = '0;
        end
      end
      ST_STALL: begin
        if (credits_reg != '0) begin
          state_next = ST_RUN;
        end else begin
          // The RUN cycle that saw zero credits plus STALL_THRESH-1 STALL
          // cycles make STALL_THRESH zero-credit cycles, so the threshold is
          // tested on the incremented count.
          stall_cnt_next = stall_cnt_reg + SW'(1);
          if (stall_cnt_next == SW'(STALL_THRESH - 1)) state_next = ST_CONGEST;
        end
      end
      ST_CONGEST: begin
        if (credits_reg >= CW'(CREDIT_MAX / 2)) state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
    if (full_persist) state_next = ST_CONGEST;
  end

  // Output logic: the hint is registered from the next state so it is
  // glitch-free and aligned with the state register.
  always_comb begin
    pifo_in_drop_next = (state_next == ST_CONGEST);
  end

  assign pifo_in_drop = pifo_in_drop_reg;

endmodule

// File: tb/tb_pifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pifo_drain_ctrl
//   Self-checking bench for pifo_drain_ctrl. The driver keeps a behavioural
//   model (credit count, output-slot occupancy, drop FIFO occupancy, run
//   lengths of zero-credit and full-FIFO cycles) and pushes every expected
//   descriptor into a queue; two monitors pop and compare whenever the DUT
//   presents an output.
// -----------------------------------------------------------------------------
module tb_pifo_drain_ctrl;

  localparam int BITPRIO = 16;
  localparam int BITDESC = 32;
  localparam int CMAX    = 8;
  localparam int DDEPTH  = 4;
  localparam int STHRESH = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               pifo_out_ready;
  logic               pifo_out_valid;
  logic [BITPRIO-1:0] pifo_out_prio;
  logic [BITDESC-1:0] pifo_out_data;
  logic               pifo_out_drop_valid;
  logic [BITPRIO-1:0] pifo_out_drop_prio;
  logic [BITDESC-1:0] pifo_out_drop_data;
  logic               m_desc_valid;
  logic               m_desc_ready;
  logic [BITPRIO-1:0] m_desc_prio;
  logic [BITDESC-1:0] m_desc_data;
  logic               credit_return;
  logic               m_drop_valid;
  logic               m_drop_ready;
  logic [BITPRIO-1:0] m_drop_prio;
  logic [BITDESC-1:0] m_drop_data;
  logic               pifo_in_drop;
  logic [31:0]        stat_drop_cnt;
  logic [15:0]        stat_lost_cnt;
  logic               credit_err;

  pifo_drain_ctrl #(
    .BITPRIO(BITPRIO), .BITDESC(BITDESC), .CREDIT_MAX(CMAX),
    .DROP_FIFO_DEPTH(DDEPTH), .STALL_THRESH(STHRESH)
  ) dut (
    .clk(clk), .rst(rst),
    .pifo_out_ready(pifo_out_ready), .pifo_out_valid(pifo_out_valid),
    .pifo_out_prio(pifo_out_prio), .pifo_out_data(pifo_out_data),
    .pifo_out_drop_valid(pifo_out_drop_valid), .pifo_out_drop_prio(pifo_out_drop_prio),
    .pifo_out_drop_data(pifo_out_drop_data),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .m_desc_prio(m_desc_prio), .m_desc_data(m_desc_data),
    .credit_return(credit_return),
    .m_drop_valid(m_drop_valid), .m_drop_ready(m_drop_ready),
    .m_drop_prio(m_drop_prio), .m_drop_data(m_drop_data),
    .pifo_in_drop(pifo_in_drop), .stat_drop_cnt(stat_drop_cnt),
    .stat_lost_cnt(stat_lost_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [47:0] exp_desc_q[$];
  logic [47:0] exp_drop_q[$];

  // Behavioural model state
  int          credits_m  = CMAX;
  bit          slot_m     = 0;
  bit          err_m      = 0;
  int          occ_m      = 0;
  logic [31:0] drops_m    = '0;
  logic [15:0] lost_m     = '0;
  int          zero_run_m = 0;
  int          full_run_m = 0;
  bit          cong_m     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_drop_stat();
`ifdef PIFO_DRAIN_STATS_EN
    return drops_m;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_lost_stat();
`ifdef PIFO_DRAIN_STATS_EN
    return lost_m;
`else
    return 16'd0;
`endif
  endfunction

  task automatic reset_model();
    credits_m = CMAX; slot_m = 0; err_m = 0; occ_m = 0;
    drops_m = '0; lost_m = '0; zero_run_m = 0; full_run_m = 0; cong_m = 0;
    exp_desc_q.delete();
    exp_drop_q.delete();
  endtask

  // One clock cycle: inputs already set; check at negedge, advance the model,
  // return just after the next posedge.
  task automatic tick();
    bit exp_ready, pop_m, drd_m, forced;
    int credits_now, occ_now;
    @(negedge clk);
    exp_ready = (credits_m != 0) && (!slot_m || m_desc_ready);
    chk("pifo_out_ready", pifo_out_ready, exp_ready);
    chk("m_desc_valid", m_desc_valid, slot_m);
    chk("m_drop_valid", m_drop_valid, occ_m != 0);
    chk("pifo_in_drop", pifo_in_drop, cong_m);
    chk("credit_err", credit_err, err_m);
    chk("stat_drop_cnt", stat_drop_cnt, exp_drop_stat());
    chk("stat_lost_cnt", stat_lost_cnt, exp_lost_stat());

    credits_now = credits_m;
    occ_now     = occ_m;
    pop_m = pifo_out_valid && exp_ready;
    if (pop_m) exp_desc_q.push_back({pifo_out_prio, pifo_out_data});
    if (pop_m && !credit_return) credits_m--;
    else if (!pop_m && credit_return) begin
      if (credits_m == CMAX) err_m = 1;
      else credits_m++;
    end
    if (pop_m) slot_m = 1;
    else if (m_desc_ready) slot_m = 0;

    drd_m = m_drop_ready && (occ_m != 0);
    if (pifo_out_drop_valid) begin
      drops_m = drops_m + 32'd1;
      if (occ_m < DDEPTH || drd_m) begin
        exp_drop_q.push_back({pifo_out_drop_prio, pifo_out_drop_data});
        occ_m++;
      end else begin
        lost_m = lost_m + 16'd1;
      end
    end
    if (drd_m) occ_m--;

    zero_run_m = (credits_now == 0) ? zero_run_m + 1 : 0;
    full_run_m = (occ_now == DDEPTH) ? full_run_m + 1 : 0;
    forced = (full_run_m >= 2);
    if (forced) cong_m = 1;
    else if (cong_m) cong_m = !(credits_now >= CMAX / 2);
    else cong_m = (zero_run_m >= STHRESH);

    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input bit v);
    pifo_out_valid = v;
    pifo_out_prio  = BITPRIO'($urandom);
    pifo_out_data  = $urandom;
  endtask

  task automatic set_drop(input bit v);
    pifo_out_drop_valid = v;
    pifo_out_drop_prio  = BITPRIO'($urandom);
    pifo_out_drop_data  = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, pifo_out_ready, 0);
    chk({tag, "_desc_valid"}, m_desc_valid, 0);
    chk({tag, "_desc_prio"}, m_desc_prio, 0);
    chk({tag, "_desc_data"}, m_desc_data, 0);
    chk({tag, "_drop_valid"}, m_drop_valid, 0);
    chk({tag, "_drop_prio"}, m_drop_prio, 0);
    chk({tag, "_drop_data"}, m_drop_data, 0);
    chk({tag, "_in_drop"}, pifo_in_drop, 0);
    chk({tag, "_credit_err"}, credit_err, 0);
    chk({tag, "_stat_drop"}, stat_drop_cnt, 0);
    chk({tag, "_stat_lost"}, stat_lost_cnt, 0);
  endtask

  // Forwarded-descriptor monitor
  always @(negedge clk) begin
    if (!rst && m_desc_valid) begin
      if (exp_desc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL desc_unexpected: got prio=%0h data=%0h expected none at %0t",
                 m_desc_prio, m_desc_data, $time);
      end else begin
        chk("desc_prio", m_desc_prio, exp_desc_q[0][47:32]);
        chk("desc_data", m_desc_data, exp_desc_q[0][31:0]);
        if (m_desc_ready) void'(exp_desc_q.pop_front());
      end
    end
  end

  // Drop release monitor
  always @(negedge clk) begin
    if (!rst && m_drop_valid) begin
      if (exp_drop_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL drop_unexpected: got prio=%0h data=%0h expected none at %0t",
                 m_drop_prio, m_drop_data, $time);
      end else begin
        chk("drop_prio", m_drop_prio, exp_drop_q[0][47:32]);
        chk("drop_data", m_drop_data, exp_drop_q[0][31:0]);
        if (m_drop_ready) void'(exp_drop_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    pifo_out_valid = 0; pifo_out_prio = '0; pifo_out_data = '0;
    pifo_out_drop_valid = 0; pifo_out_drop_prio = '0; pifo_out_drop_data = '0;
    m_desc_ready = 0; credit_return = 0; m_drop_ready = 0;
    #3;
    chk_all_zero("reset");
    #19 rst = 1'b0;
    @(posedge clk); #1;

    // 8 pops with a ready sink and no credit return; the 9th must be refused
    m_desc_ready = 1;
    for (int i = 0; i < 9; i++) begin set_desc(1); tick(); end
    set_desc(0);
    chk("ready_after_8_pops", pifo_out_ready, 0);

    // Downstream stall holds the output register
    credit_return = 1; tick(); tick(); credit_return = 0;
    pifo_out_valid = 1; pifo_out_prio = 16'h0010; pifo_out_data = 32'hDEADBEEF;
    m_desc_ready = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      set_desc(1);
      chk("hold_prio", m_desc_prio, 16'h0010);
      chk("hold_data", m_desc_data, 32'hDEADBEEF);
      chk("hold_ready", pifo_out_ready, 0);
      tick();
    end
    set_desc(0); m_desc_ready = 1; tick();

    // Refill to CREDIT_MAX, then pop and return in the same cycle
    credit_return = 1;
    for (int i = 0; i < 7; i++) tick();
    for (int i = 0; i < 10; i++) begin set_desc(1); tick(); end
    set_desc(0);
    chk("credit_err_before_extra", credit_err, 0);
    tick();                                   // extra return at CREDIT_MAX
    credit_return = 0;
    chk("credit_err_set", credit_err, 1);
    tick();

    // Six back-to-back drops into a stalled drop path
    m_drop_ready = 0;
    for (int i = 0; i < 6; i++) begin set_drop(1); tick(); end
    set_drop(0);
`ifdef PIFO_DRAIN_STATS_EN
    chk("drop_cnt_6", stat_drop_cnt, 6);
    chk("lost_cnt_2", stat_lost_cnt, 2);
`else
    chk("drop_cnt_off", stat_drop_cnt, 0);
    chk("lost_cnt_off", stat_lost_cnt, 0);
`endif
    m_drop_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("drop_drained", m_drop_valid, 0);

    // Credit starvation: 8 pops, then zero credits for 64 cycles
    for (int i = 0; i < 8; i++) begin set_desc(1); tick(); end
    set_desc(0);
    for (int i = 0; i < 63; i++) tick();
    chk("no_congest_cycle_64", pifo_in_drop, 0);
    tick();
    chk("congest_cycle_65", pifo_in_drop, 1);
    credit_return = 1;
    for (int i = 0; i < 3; i++) tick();
    credit_return = 0;
    tick();
    chk("congest_with_3_credits", pifo_in_drop, 1);
    credit_return = 1; tick(); credit_return = 0;
    tick();
    chk("run_with_4_credits", pifo_in_drop, 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      set_desc($urandom_range(0, 9) < 6);
      m_desc_ready  = ($urandom_range(0, 9) < 7);
      credit_return = ($urandom_range(0, 9) < 4);
      set_drop($urandom_range(0, 9) < 4);
      m_drop_ready  = ($urandom_range(0, 9) < 5);
      tick();
    end
    set_drop(0); m_drop_ready = 1;

    // Reset in the middle of a transfer
    set_desc(0); m_desc_ready = 1; credit_return = 1;
    for (int i = 0; i < 8; i++) tick();
    credit_return = 0; m_desc_ready = 0;
    set_desc(1); tick(); set_desc(0);
    chk("pre_reset_valid", m_desc_valid, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    reset_model();
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    m_desc_ready = 1;
    for (int i = 0; i < 9; i++) begin set_desc(1); tick(); end
    set_desc(0);
    chk("ready_after_reset_8", pifo_out_ready, 0);

    for (int i = 0; i < 6; i++) tick();
    chk("desc_queue_empty", exp_desc_q.size(), 0);
    chk("drop_queue_empty", exp_drop_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
